// File: rtl/div_pkg.sv
// ============================================================================
// Module      : div_pkg
// Description : Shared state encoding, constants and helpers for the
//               sequential divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int DIV_ITER = 32;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

    // Conditional two's-complement negate: used for both the operand
    // magnitudes and the final sign fix-up.
    function automatic logic [31:0] cond_neg(input logic [31:0] x, input logic neg);
        return neg ? (~x + 32'd1) : x;
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_seq_if.sv
// ============================================================================
// Module      : div_seq_if
// Description : Launch/result bundle between the EX stage and the divider.
//               Optional macro: DIV_ZERO_FLAG_EN adds div_zero_o.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_seq_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic             signed_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cancel_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] quo_o;
    logic [WIDTH-1:0] rem_o;
`ifdef DIV_ZERO_FLAG_EN
    logic             div_zero_o;
`endif

    modport master (
`ifdef DIV_ZERO_FLAG_EN
        input  div_zero_o,
`endif
        output start_i, signed_i, a_i, b_i, cancel_i,
        input  busy_o, done_o, quo_o, rem_o
    );

    modport slave (
`ifdef DIV_ZERO_FLAG_EN
        output div_zero_o,
`endif
        input  start_i, signed_i, a_i, b_i, cancel_i,
        output busy_o, done_o, quo_o, rem_o
    );

endinterface

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division step on a 33-bit
//               subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step #(
    parameter int WIDTH = 32
) (
    input  wire [WIDTH-1:0] r,
    input  wire             dvd_msb,
    input  wire [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] r_next,
    output logic             q_bit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    always_comb begin
        w_shift = {r, dvd_msb};
        w_diff  = w_shift - {1'b0, dvs};
        q_bit   = ~w_diff[WIDTH];
        // A borrow means the divisor did not fit: keep the shifted remainder.
        r_next  = q_bit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    end

endmodule

`default_nettype wire

// File: rtl/div_seq.sv
// ============================================================================
// Module      : div_seq
// Description : Iterative 32-bit DIV/DIVU sequencer with sign fix-up.
//               Optional macro: DIV_ZERO_FLAG_EN (fast divide-by-zero path).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  wire     clk,
    input  wire     rst,
    div_seq_if.slave bus
);

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo_out;
    logic [WIDTH-1:0] r_rem_out;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_q_bit;
    logic             w_launch;
    logic             w_skip_run;
    logic             w_sign_a;
    logic             w_sign_b;
    logic             w_busy;
    logic             w_done;

    assign w_launch = (r_state == S_IDLE) && bus.start_i && !bus.cancel_i;
    assign w_sign_a = bus.signed_i & bus.a_i[WIDTH-1];
    assign w_sign_b = bus.signed_i & bus.b_i[WIDTH-1];

`ifdef DIV_ZERO_FLAG_EN
    logic r_zero;
    assign w_skip_run     = w_launch && (bus.b_i == '0);
    assign bus.div_zero_o = w_done && r_zero;
`else
    assign w_skip_run = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .r       (r_rem),
        .dvd_msb (r_dvd[WIDTH-1]),
        .dvs     (r_dvs),
        .r_next  (w_rem_next),
        .q_bit   (w_q_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_launch) w_next = w_skip_run ? S_FIX : S_RUN;
            S_RUN: begin
                if (bus.cancel_i)                             w_next = S_IDLE;
                else if (r_cnt == CNT_W'(DIV_ITER - 1))       w_next = S_FIX;
            end
            S_FIX:   w_next = bus.cancel_i ? S_IDLE : S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == S_RUN) || (r_state == S_FIX);
        w_done = (r_state == S_DONE);
    end

    assign bus.busy_o = w_busy;
    assign bus.done_o = w_done;
    assign bus.quo_o  = r_quo_out;
    assign bus.rem_o  = r_rem_out;

    // r_dvd doubles as the quotient register: quotient bits shift in at the LSB
    // as dividend bits leave at the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_rem     <= '0;
            r_quo_out <= '0;
            r_rem_out <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            r_zero    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_dvd   <= cond_neg(bus.a_i, w_sign_a);
                        r_dvs   <= cond_neg(bus.b_i, w_sign_b);
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_neg_q <= w_sign_a ^ w_sign_b;
                        r_neg_r <= w_sign_a;
`ifdef DIV_ZERO_FLAG_EN
                        r_zero  <= w_skip_run;
                        // Preload the raw zero-divide result so FIX passes it through.
                        if (w_skip_run) begin
                            r_dvd   <= DIV_ZERO_Q;
                            r_rem   <= bus.a_i;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end
`endif
                    end
                end
                S_RUN: begin
                    if (!bus.cancel_i) begin
                        r_rem <= w_rem_next;
                        r_dvd <= {r_dvd[WIDTH-2:0], w_q_bit};
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_FIX: begin
                    if (!bus.cancel_i) begin
                        r_quo_out <= cond_neg(r_dvd, r_neg_q);
                        r_rem_out <= cond_neg(r_rem, r_neg_r);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div_seq.sv
// ============================================================================
// Module      : tb_div_seq
// Description : Directed self-checking bench for div_seq with a result
//               scoreboard. Honours DIV_ZERO_FLAG_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_seq;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    div_seq_if bus ();

    div_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
    } res_t;

    res_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eq,
                           input logic [31:0] er, input int exp_lat,
                           input int exp_busy, input logic exp_zero);
        int   cyc;
        int   nbusy;
        logic got;
        logic zflag;
        res_t exp;
        sb_q.push_back('{q: eq, r: er});
        @(negedge clk);
        bus.start_i  = 1'b1;
        bus.signed_i = s;
        bus.a_i      = a;
        bus.b_i      = b;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        cyc   = 0;
        nbusy = 0;
        got   = 1'b0;
        zflag = 1'b0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.busy_o) nbusy++;
            if (bus.done_o) begin
                got = 1'b1;
`ifdef DIV_ZERO_FLAG_EN
                zflag = bus.div_zero_o;
`endif
            end
        end
        exp = sb_q.pop_front();
        check({tag, " done_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, " quo"}, bus.quo_o, exp.q);
            check({tag, " rem"}, bus.rem_o, exp.r);
            check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
            check({tag, " busy_cycles"}, 32'(nbusy), 32'(exp_busy));
`ifdef DIV_ZERO_FLAG_EN
            check({tag, " div_zero"}, 32'(zflag), 32'(exp_zero));
`else
            if (exp_zero) zflag = 1'b0;
`endif
            @(negedge clk);
            check({tag, " done_pulse_width"}, 32'(bus.done_o), 32'd0);
        end
    endtask

    task automatic expect_no_done(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done_o) seen++;
        end
        check({tag, " no_done"}, 32'(seen), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.start_i  = 1'b0;
        bus.signed_i = 1'b0;
        bus.a_i      = '0;
        bus.b_i      = '0;
        bus.cancel_i = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(bus.busy_o), 32'd0);
        check("reset done", 32'(bus.done_o), 32'd0);
        check("reset quo", bus.quo_o, 32'd0);
        check("reset rem", bus.rem_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34, 33, 1'b0);

        // Launch 9/3 and flush it at RUN cycle 10.
        @(negedge clk);
        bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.a_i = 32'd9; bus.b_i = 32'd3;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        repeat (10) @(negedge clk);
        bus.cancel_i = 1'b1;
        @(posedge clk);
        #1 bus.cancel_i = 1'b0;
        @(negedge clk);
        check("cancel busy", 32'(bus.busy_o), 32'd0);
        expect_no_done("cancel", 40);
        check("cancel quo_hold", bus.quo_o, 32'd14);
        check("cancel rem_hold", bus.rem_o, 32'd2);

        // start together with cancel in IDLE must not launch.
        @(negedge clk);
        bus.start_i = 1'b1; bus.cancel_i = 1'b1; bus.a_i = 32'd50; bus.b_i = 32'd5;
        @(posedge clk);
        #1 begin bus.start_i = 1'b0; bus.cancel_i = 1'b0; end
        @(negedge clk);
        check("start_cancel busy", 32'(bus.busy_o), 32'd0);
        expect_no_done("start_cancel", 40);

        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34, 33, 1'b0);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 34, 33, 1'b0);
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 34, 33, 1'b0);
        run_div("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 34, 33, 1'b0);
        run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 34, 33, 1'b0);
        run_div("divu_big", 1'b0, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF, 34, 33, 1'b0);
`ifdef DIV_ZERO_FLAG_EN
        run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 2, 1, 1'b1);
`else
        run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 34, 33, 1'b0);
`endif

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.a_i = 32'd1000; bus.b_i = 32'd3;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst busy", 32'(bus.busy_o), 32'd0);
        check("midrst done", 32'(bus.done_o), 32'd0);
        check("midrst quo", bus.quo_o, 32'd0);
        check("midrst rem", bus.rem_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        expect_no_done("midrst", 20);
        run_div("post_rst_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34, 33, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
